// File: rtl/contador_pkg.sv
// Shared types and helpers for the modulo up/down counter with auto-repeat.
package contador_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRIMERO = 2'd1,
      REPITE  = 2'd2,
      ESPERA  = 2'd3
   } estado_t;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_INC  = 2'b01;
   localparam logic [1:0] DIR_DEC  = 2'b10;

   function automatic int clog2(input int valor);
      int r;
      r = 0;
      while ((1 << r) < valor) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/temporizador_rep.sv
// Press-and-hold repeat sequencer: first step on press, then after RETARDO, then every PERIODO.
//
// state   | meaning
// IDLE    | no button held, next single-direction sample steps at once
// PRIMERO | first step applied, down-counting the initial repeat delay
// REPITE  | auto-repeating, one step every PERIODO cycles
// ESPERA  | locked out (load, both buttons, direction change) until both released
module temporizador_rep
   import contador_pkg::*;
#(
   parameter int RETARDO = 4,
   parameter int PERIODO = 2
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Arranca,
   input  logic i_Activo,
   input  logic i_Sigue,
   input  logic i_Carga,
   output logic o_Tick
);

   localparam int MAX_RP = (RETARDO > PERIODO) ? RETARDO : PERIODO;
   localparam int ANCHO  = clog2(MAX_RP + 1);
   localparam logic [ANCHO-1:0] T_RET = ANCHO'(RETARDO - 1);
   localparam logic [ANCHO-1:0] T_PER = ANCHO'(PERIODO - 1);

   estado_t          estado, estado_sig;
   logic [ANCHO-1:0] timer, timer_sig;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         estado <= IDLE;
         timer  <= '0;
      end else begin
         estado <= estado_sig;
         timer  <= timer_sig;
      end
   end

   // Timer counts down to terminal count 0; only decremented while nonzero, so it never wraps.
   always_comb begin
      estado_sig = estado;
      timer_sig  = timer;
      o_Tick     = 1'b0;
      if (i_Carga) begin
         estado_sig = ESPERA;
         timer_sig  = '0;
      end else begin
         case (estado)
            IDLE: begin
               if (i_Arranca) begin
                  o_Tick     = 1'b1;
                  timer_sig  = T_RET;
                  estado_sig = PRIMERO;
               end else if (i_Activo) begin
                  estado_sig = ESPERA;
               end
            end
            PRIMERO, REPITE: begin
               if (i_Sigue) begin
                  if (timer == '0) begin
                     o_Tick     = 1'b1;
                     timer_sig  = T_PER;
                     estado_sig = REPITE;
                  end else begin
                     timer_sig = timer - 1'b1;
                  end
               end else begin
                  timer_sig  = '0;
                  estado_sig = i_Activo ? ESPERA : IDLE;
               end
            end
            ESPERA: begin
               if (!i_Activo) estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/contador_mod_rep.sv
// Modulo-MOD up/down counter with parallel load, carry/borrow/step pulses and auto-repeat.
module contador_mod_rep
   import contador_pkg::*;
#(
   parameter int N       = 8,
   parameter int MOD     = 256,
   parameter int RETARDO = 4,
   parameter int PERIODO = 2
) (
   input  logic         i_Clk,
   input  logic         i_Rst,
   input  logic         i_Inc,
   input  logic         i_Dec,
   input  logic         i_Load,
   input  logic [N-1:0] i_Dato,
   output logic [N-1:0] o_Cta,
   output logic         o_Carry,
   output logic         o_Borrow,
   output logic         o_Paso
);

   localparam logic [N-1:0] CTA_MAX = N'(MOD - 1);

   logic [1:0] dir_cur, dir_prev;
   logic       arranca, activo, sigue, tick;

   always_comb begin
      dir_cur = DIR_NONE;
      if (i_Inc && !i_Dec)      dir_cur = DIR_INC;
      else if (i_Dec && !i_Inc) dir_cur = DIR_DEC;
   end

   // A hold continues only if the same single direction was also sampled last cycle.
   assign arranca = (dir_cur != DIR_NONE);
   assign activo  = i_Inc | i_Dec;
   assign sigue   = arranca && (dir_cur == dir_prev);

   temporizador_rep #(
      .RETARDO (RETARDO),
      .PERIODO (PERIODO)
   ) u_temporizador_rep (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .i_Arranca (arranca),
      .i_Activo  (activo),
      .i_Sigue   (sigue),
      .i_Carga   (i_Load),
      .o_Tick    (tick)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Cta    <= '0;
         o_Carry  <= 1'b0;
         o_Borrow <= 1'b0;
         o_Paso   <= 1'b0;
         dir_prev <= DIR_NONE;
      end else begin
         dir_prev <= dir_cur;
         o_Carry  <= 1'b0;
         o_Borrow <= 1'b0;
         o_Paso   <= 1'b0;
         if (i_Load) begin
            o_Cta <= (i_Dato > CTA_MAX) ? CTA_MAX : i_Dato;
         end else if (tick) begin
            o_Paso <= 1'b1;
            if (dir_cur == DIR_INC) begin
               if (o_Cta == CTA_MAX) begin
                  o_Cta   <= '0;
                  o_Carry <= 1'b1;
               end else begin
                  o_Cta <= o_Cta + N'(1);
               end
            end else begin
               if (o_Cta == '0) begin
                  o_Cta    <= CTA_MAX;
                  o_Borrow <= 1'b1;
               end else begin
                  o_Cta <= o_Cta - N'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_contador_mod_rep.sv
// Self-checking bench: vector table, hand-written corner sequences and random holds vs a hold-length model.
module tb_contador_mod_rep;

   localparam int N   = 4;
   localparam int MOD = 10;
   localparam int RET = 4;
   localparam int PER = 2;

   logic         i_Clk = 1'b0;
   logic         i_Rst, i_Inc, i_Dec, i_Load;
   logic [N-1:0] i_Dato;
   logic [N-1:0] o_Cta;
   logic         o_Carry, o_Borrow, o_Paso;

   int checks = 0;
   int errors = 0;

   // Model state: count, how many cycles the current direction has been held, lockout flag.
   int m_cta, m_len, m_dir;
   bit m_bloq;
   bit e_carry, e_borrow, e_paso;

   typedef struct {
      logic         inc, dec, ld;
      logic [N-1:0] dato;
      logic [N-1:0] cta;
      logic         c, b, p;
   } vec_t;

   vec_t tabla[$];

   contador_mod_rep #(.N(N), .MOD(MOD), .RETARDO(RET), .PERIODO(PER)) dut (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .i_Inc    (i_Inc),
      .i_Dec    (i_Dec),
      .i_Load   (i_Load),
      .i_Dato   (i_Dato),
      .o_Cta    (o_Cta),
      .o_Carry  (o_Carry),
      .o_Borrow (o_Borrow),
      .o_Paso   (o_Paso)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string nom, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got cta/c/b/p=%h expected %h", nom, got, exp);
      end
   endtask

   function automatic logic [6:0] salida();
      return {o_Cta, o_Carry, o_Borrow, o_Paso};
   endfunction

   task automatic modelo_reset();
      m_cta = 0; m_len = 0; m_dir = 0; m_bloq = 0;
      e_carry = 0; e_borrow = 0; e_paso = 0;
   endtask

   task automatic modelo(input logic inc, input logic dec, input logic ld, input logic [N-1:0] dato);
      int d;
      e_carry = 0; e_borrow = 0; e_paso = 0;
      if (ld) begin
         m_cta  = (int'(dato) > MOD - 1) ? MOD - 1 : int'(dato);
         m_bloq = 1; m_len = 0;
      end else if (m_bloq) begin
         if (!inc && !dec) m_bloq = 0;
      end else if (inc && dec) begin
         m_bloq = 1; m_len = 0;
      end else if (!inc && !dec) begin
         m_len = 0;
      end else begin
         d = inc ? 1 : 2;
         if (m_len > 0 && d != m_dir) begin
            m_bloq = 1; m_len = 0;
         end else begin
            if (m_len == 0 || m_len == RET || (m_len > RET && (m_len - RET) % PER == 0)) begin
               e_paso = 1;
               if (d == 1) begin
                  if (m_cta == MOD - 1) begin m_cta = 0; e_carry = 1; end
                  else m_cta = m_cta + 1;
               end else begin
                  if (m_cta == 0) begin m_cta = MOD - 1; e_borrow = 1; end
                  else m_cta = m_cta - 1;
               end
            end
            m_dir = d;
            m_len = m_len + 1;
         end
      end
   endtask

   function automatic logic [6:0] esperado();
      return {N'(m_cta), e_carry, e_borrow, e_paso};
   endfunction

   task automatic paso(input logic inc, input logic dec, input logic ld, input logic [N-1:0] dato,
                       input string nom);
      i_Inc = inc; i_Dec = dec; i_Load = ld; i_Dato = dato;
      @(posedge i_Clk);
      modelo(inc, dec, ld, dato);
      #1;
      chk(nom, salida(), esperado());
   endtask

   initial begin
      i_Rst = 1'b1; i_Inc = 0; i_Dec = 0; i_Load = 0; i_Dato = '0;
      modelo_reset();
      #12;
      chk("reset", salida(), 7'd0);
      @(negedge i_Clk);
      i_Rst = 1'b0;

      //           inc dec ld dato cta c b p
      tabla.push_back('{0, 0, 1, 4'd7,  4'd7, 0, 0, 0});
      tabla.push_back('{0, 0, 0, 4'd0,  4'd7, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd8, 0, 0, 1});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd8, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd8, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd8, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd9, 0, 0, 1});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd9, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd0, 1, 0, 1});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd0, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd1, 0, 0, 1});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd1, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd2, 0, 0, 1});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd2, 0, 0, 0});
      tabla.push_back('{0, 0, 0, 4'd0,  4'd2, 0, 0, 0});
      tabla.push_back('{0, 1, 0, 4'd0,  4'd1, 0, 0, 1});
      tabla.push_back('{0, 0, 0, 4'd0,  4'd1, 0, 0, 0});
      tabla.push_back('{0, 1, 0, 4'd0,  4'd0, 0, 0, 1});
      tabla.push_back('{0, 0, 0, 4'd0,  4'd0, 0, 0, 0});
      tabla.push_back('{0, 1, 0, 4'd0,  4'd9, 0, 1, 1});
      tabla.push_back('{0, 0, 0, 4'd0,  4'd9, 0, 0, 0});
      tabla.push_back('{0, 0, 1, 4'd12, 4'd9, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd9, 0, 0, 0});
      tabla.push_back('{0, 0, 0, 4'd0,  4'd9, 0, 0, 0});
      tabla.push_back('{1, 1, 0, 4'd0,  4'd9, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd9, 0, 0, 0});
      tabla.push_back('{0, 0, 0, 4'd0,  4'd9, 0, 0, 0});
      tabla.push_back('{1, 0, 0, 4'd0,  4'd0, 1, 0, 1});
      tabla.push_back('{0, 0, 0, 4'd0,  4'd0, 0, 0, 0});

      for (int i = 0; i < tabla.size(); i++) begin
         paso(tabla[i].inc, tabla[i].dec, tabla[i].ld, tabla[i].dato, "modelo_tabla");
         chk($sformatf("tabla[%0d]", i), salida(),
             {tabla[i].cta, tabla[i].c, tabla[i].b, tabla[i].p});
      end

      // Single tap, then 20 idle cycles with no further change.
      paso(1, 0, 0, '0, "tap");
      chk("tap_valor", salida(), {4'd1, 1'b0, 1'b0, 1'b1});
      for (int i = 0; i < 20; i++) paso(0, 0, 0, '0, "tap_quieto");
      chk("tap_final", salida(), {4'd1, 1'b0, 1'b0, 1'b0});

      // Load while holding Inc: stepping stays locked out until both are released.
      for (int i = 0; i < 6; i++) paso(1, 0, 0, '0, "hold_pre_load");
      paso(1, 0, 1, 4'd5, "load_en_hold");
      chk("load_en_hold_valor", salida(), {4'd5, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 6; i++) paso(1, 0, 0, '0, "load_bloqueo");
      chk("load_bloqueo_valor", salida(), {4'd5, 1'b0, 1'b0, 1'b0});
      paso(0, 0, 0, '0, "load_suelta");
      paso(1, 0, 0, '0, "load_tap");
      chk("load_tap_valor", salida(), {4'd6, 1'b0, 1'b0, 1'b1});

      // Both buttons from 3, then only Dec released: no step until full release and re-press.
      paso(0, 0, 1, 4'd3, "simul_load");
      paso(0, 0, 0, '0, "simul_suelta0");
      for (int i = 0; i < 10; i++) paso(1, 1, 0, '0, "simul_ambos");
      chk("simul_ambos_valor", salida(), {4'd3, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) paso(1, 0, 0, '0, "simul_solo_inc");
      chk("simul_solo_inc_valor", salida(), {4'd3, 1'b0, 1'b0, 1'b0});
      paso(0, 0, 0, '0, "simul_suelta");
      paso(1, 0, 0, '0, "simul_tap");
      chk("simul_tap_valor", salida(), {4'd4, 1'b0, 1'b0, 1'b1});

      // Asynchronous reset mid-hold at count 6; a still-held Inc counts as a new press.
      paso(0, 0, 0, '0, "rst_prep0");
      paso(0, 0, 1, 4'd5, "rst_prep_load");
      paso(0, 0, 0, '0, "rst_prep1");
      paso(1, 0, 0, '0, "rst_hold0");
      paso(1, 0, 0, '0, "rst_hold1");
      chk("rst_pre_valor", salida(), {4'd6, 1'b0, 1'b0, 1'b0});
      #2 i_Rst = 1'b1;
      #1;
      chk("rst_async", salida(), 7'd0);
      modelo_reset();
      @(negedge i_Clk);
      i_Rst = 1'b0;
      paso(1, 0, 0, '0, "rst_tras");
      chk("rst_tras_valor", salida(), {4'd1, 1'b0, 1'b0, 1'b1});

      // Random hold segments with occasional loads.
      for (int s = 0; s < 300; s++) begin
         int sel, len;
         logic ri, rd;
         sel = $urandom_range(0, 9);
         len = $urandom_range(1, 14);
         ri = (sel < 4) || (sel == 8);
         rd = (sel >= 4 && sel < 7) || (sel == 8);
         for (int k = 0; k < len; k++) begin
            logic ld;
            ld = ($urandom_range(0, 39) == 0);
            paso(ri, rd, ld, N'($urandom_range(0, 15)), "aleatorio");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
